// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the LEGv8 pipeline control blocks: hazard FSM
// states, the zero-register index and the memory opcodes the main decoder
// and the hazard logic agree on.
package cpu_ctrl_pkg;

   // Hazard controller FSM states. The value 2'd3 is never entered and
   // falls back to RUN if it is ever seen.
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hz_state_e;

   // X31 reads as zero and writes are discarded, so it never creates a
   // true data dependence.
   localparam logic [4:0] XZR = 5'd31;

   // D-format memory opcodes (instruction[31:21]).
   localparam logic [10:0] OPC_LDUR = 11'b111_1100_0010;
   localparam logic [10:0] OPC_STUR = 11'b111_1100_0000;

   // Bundle of the pipeline enables the controller produces each cycle.
   typedef struct packed {
      logic pc_write;
      logic pc_src;
      logic ifid_write;
      logic idex_bubble;
      logic flush;
      logic pipe_hold;
   } pipe_ctrl_t;

   // Nothing unusual happening: fetch advances, every register loads.
   localparam pipe_ctrl_t CTRL_IDLE   = '{pc_write: 1'b1, pc_src: 1'b0, ifid_write: 1'b1,
                                          idex_bubble: 1'b0, flush: 1'b0, pipe_hold: 1'b0};
   // Load-use: hold PC and IF/ID, inject one bubble into ID/EX.
   localparam pipe_ctrl_t CTRL_STALL  = '{pc_write: 1'b0, pc_src: 1'b0, ifid_write: 1'b0,
                                          idex_bubble: 1'b1, flush: 1'b0, pipe_hold: 1'b0};
   // Memory not ready (or hung): nothing anywhere moves.
   localparam pipe_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, pc_src: 1'b0, ifid_write: 1'b0,
                                          idex_bubble: 1'b0, flush: 1'b0, pipe_hold: 1'b1};
   // Taken branch in MEM: redirect fetch and kill the three younger stages.
   localparam pipe_ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, pc_src: 1'b1, ifid_write: 1'b1,
                                          idex_bubble: 1'b0, flush: 1'b1, pipe_hold: 1'b0};
   // While reset is held the pipe must not fetch or retire anything.
   localparam pipe_ctrl_t CTRL_RESET  = '{pc_write: 1'b0, pc_src: 1'b0, ifid_write: 1'b0,
                                          idex_bubble: 1'b1, flush: 1'b0, pipe_hold: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use comparator: flags an ID instruction that reads the register an
// EX-stage load is about to write. Purely combinational.
module load_use_detect
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rn,
   input  logic [REG_W-1:0] id_rb,
   input  logic             id_uses_b,
   input  logic             ex_memread,
   input  logic [REG_W-1:0] ex_rd,
   output logic             hazard
);

   logic rn_match;
   logic rb_match;
   logic rd_real;

   // Compare the load destination against both ID sources; the second
   // operand only counts when the instruction actually reads it, and a
   // load into XZR never produces a value anyone can depend on.
   always_comb begin
      rd_real  = (ex_rd != REG_W'(XZR));
      rn_match = (ex_rd == id_rn);
      rb_match = id_uses_b && (ex_rd == id_rb);
      hazard   = ex_memread && rd_real && id_valid && (rn_match || rb_match);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the five-stage LEGv8 pipeline. Drives
// PC and pipeline-register enables for load-use bubbles, taken-branch
// flushes and data-memory wait states, with a hung-memory watchdog and
// saturating stall/flush performance counters.
module pipe_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int PERF_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              ID_VALID,
   input  logic [REG_W-1:0]  ID_RN,
   input  logic [REG_W-1:0]  ID_RB,
   input  logic              ID_USES_B,
   input  logic              EX_MEMREAD,
   input  logic [REG_W-1:0]  EX_RD,
   input  logic              MEM_TAKEN,
   input  logic              MEM_REQ,
   input  logic              MEM_READY,
   output logic              PC_WRITE,
   output logic              PC_SRC,
   output logic              IFID_WRITE,
   output logic              IDEX_BUBBLE,
   output logic              FLUSH,
   output logic              PIPE_HOLD,
   output logic [1:0]        STATE,
   output logic              MEM_ERR,
   output logic [PERF_W-1:0] STALL_COUNT,
   output logic [PERF_W-1:0] FLUSH_COUNT
);

   // Wide enough to hold TIMEOUT itself.
   localparam int CW = $clog2(TIMEOUT + 1);

   hz_state_e         state_q;
   hz_state_e         state_d;
   logic [CW-1:0]     wait_q;
   logic [CW-1:0]     wait_d;
   logic [CW-1:0]     wait_inc;
   logic              hazard;
   logic              mem_err_q;
   logic [PERF_W-1:0] stall_q;
   logic [PERF_W-1:0] flush_q;
   pipe_ctrl_t        ctrl;
   logic              run_rules;

   load_use_detect #(
      .REG_W(REG_W)
   ) u_load_use (
      .id_valid  (ID_VALID),
      .id_rn     (ID_RN),
      .id_rb     (ID_RB),
      .id_uses_b (ID_USES_B),
      .ex_memread(EX_MEMREAD),
      .ex_rd     (EX_RD),
      .hazard    (hazard)
   );

   // Next state and pipeline controls. A memory wait that completes this
   // cycle is handled exactly like RUN so a pending load-use still bubbles
   // on the release cycle. Reset overrides everything at the end.
   always_comb begin
      ctrl      = CTRL_IDLE;
      state_d   = state_q;
      wait_d    = wait_q;
      wait_inc  = wait_q + CW'(1);
      run_rules = (state_q == RUN) || ((state_q == MEM_WAIT) && MEM_READY);

      if (run_rules) begin
         state_d = RUN;
         wait_d  = '0;
         if (MEM_TAKEN) begin
            ctrl = CTRL_FLUSH;
         end else if (MEM_REQ && !MEM_READY) begin
            ctrl    = CTRL_FREEZE;
            state_d = MEM_WAIT;
            wait_d  = CW'(1);
         end else if (hazard) begin
            ctrl = CTRL_STALL;
         end
      end else begin
         case (state_q)
            MEM_WAIT: begin
               ctrl   = CTRL_FREEZE;
               wait_d = wait_inc;
               if (wait_inc >= CW'(TIMEOUT)) begin
                  state_d = ERROR;
               end else begin
                  state_d = MEM_WAIT;
               end
            end
            ERROR: begin
               ctrl    = CTRL_FREEZE;
               state_d = ERROR;
            end
            default: begin
               ctrl    = CTRL_IDLE;
               state_d = RUN;
               wait_d  = '0;
            end
         endcase
      end

      if (RESET) begin
         ctrl = CTRL_RESET;
      end
   end

   // FSM state, wait counter and the sticky watchdog flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q   <= RUN;
         wait_q    <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         if (state_d == ERROR) begin
            mem_err_q <= 1'b1;
         end
      end
   end

   // Saturating performance counters. A hung pipe in ERROR is not counted
   // as stall time, so the count stays meaningful after a watchdog trip.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!ctrl.pc_write && (state_q != ERROR) && (stall_q != '1)) begin
            stall_q <= stall_q + PERF_W'(1);
         end
         if (ctrl.flush && (flush_q != '1)) begin
            flush_q <= flush_q + PERF_W'(1);
         end
      end
   end

   assign PC_WRITE    = ctrl.pc_write;
   assign PC_SRC      = ctrl.pc_src;
   assign IFID_WRITE  = ctrl.ifid_write;
   assign IDEX_BUBBLE = ctrl.idex_bubble;
   assign FLUSH       = ctrl.flush;
   assign PIPE_HOLD   = ctrl.pipe_hold;
   assign STATE       = state_q;
   assign MEM_ERR     = mem_err_q;
   assign STALL_COUNT = stall_q;
   assign FLUSH_COUNT = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl. Built with a short
// watchdog and narrow counters so timeout and saturation are reachable.
module tb_pipe_hazard_ctrl;

   localparam int REG_W   = 5;
   localparam int PERF_W  = 4;
   localparam int TIMEOUT = 4;

   // Control vector order: {PC_WRITE, PC_SRC, IFID_WRITE, IDEX_BUBBLE, FLUSH, PIPE_HOLD}
   localparam logic [5:0] C_IDLE   = 6'b101000;
   localparam logic [5:0] C_STALL  = 6'b000100;
   localparam logic [5:0] C_FREEZE = 6'b000001;
   localparam logic [5:0] C_FLUSH  = 6'b111010;
   localparam logic [5:0] C_RESET  = 6'b000101;

   logic              CLK;
   logic              RESET;
   logic              ID_VALID;
   logic [REG_W-1:0]  ID_RN;
   logic [REG_W-1:0]  ID_RB;
   logic              ID_USES_B;
   logic              EX_MEMREAD;
   logic [REG_W-1:0]  EX_RD;
   logic              MEM_TAKEN;
   logic              MEM_REQ;
   logic              MEM_READY;
   logic              PC_WRITE;
   logic              PC_SRC;
   logic              IFID_WRITE;
   logic              IDEX_BUBBLE;
   logic              FLUSH;
   logic              PIPE_HOLD;
   logic [1:0]        STATE;
   logic              MEM_ERR;
   logic [PERF_W-1:0] STALL_COUNT;
   logic [PERF_W-1:0] FLUSH_COUNT;
   logic [5:0]        ctrl;

   int testsRun;
   int testsFailed;

   pipe_hazard_ctrl #(
      .REG_W  (REG_W),
      .PERF_W (PERF_W),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .ID_VALID   (ID_VALID),
      .ID_RN      (ID_RN),
      .ID_RB      (ID_RB),
      .ID_USES_B  (ID_USES_B),
      .EX_MEMREAD (EX_MEMREAD),
      .EX_RD      (EX_RD),
      .MEM_TAKEN  (MEM_TAKEN),
      .MEM_REQ    (MEM_REQ),
      .MEM_READY  (MEM_READY),
      .PC_WRITE   (PC_WRITE),
      .PC_SRC     (PC_SRC),
      .IFID_WRITE (IFID_WRITE),
      .IDEX_BUBBLE(IDEX_BUBBLE),
      .FLUSH      (FLUSH),
      .PIPE_HOLD  (PIPE_HOLD),
      .STATE      (STATE),
      .MEM_ERR    (MEM_ERR),
      .STALL_COUNT(STALL_COUNT),
      .FLUSH_COUNT(FLUSH_COUNT)
   );

   assign ctrl = {PC_WRITE, PC_SRC, IFID_WRITE, IDEX_BUBBLE, FLUSH, PIPE_HOLD};

   // 10 ns free-running clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Count one comparison and report it if the observed value is wrong.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's worth of inputs, then let the combinational outputs settle.
   task automatic applyStimulus(input logic vld, input logic [4:0] rn, input logic [4:0] rb,
                                input logic usesB, input logic memRead, input logic [4:0] rd,
                                input logic taken, input logic req, input logic ready);
      ID_VALID   = vld;
      ID_RN      = rn;
      ID_RB      = rb;
      ID_USES_B  = usesB;
      EX_MEMREAD = memRead;
      EX_RD      = rd;
      MEM_TAKEN  = taken;
      MEM_REQ    = req;
      MEM_READY  = ready;
      #1;
   endtask

   // Advance one clock edge and land mid-low-phase, away from the edge.
   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
      #1;
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      RESET       = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      RESET = 1'b1;
      #1;

      // Reset values and forced controls
      checkOutput("reset_ctrl", 32'(ctrl), 32'(C_RESET));
      checkOutput("reset_state", 32'(STATE), 32'd0);
      checkOutput("reset_memerr", 32'(MEM_ERR), 32'd0);
      checkOutput("reset_stall", 32'(STALL_COUNT), 32'd0);
      checkOutput("reset_flush", 32'(FLUSH_COUNT), 32'd0);

      @(negedge CLK);
      #1;
      RESET = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("idle_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();
      checkOutput("idle_stall", 32'(STALL_COUNT), 32'd0);

      // Load-use on Rn: one bubble cycle, state stays RUN
      applyStimulus(1, 2, 0, 0, 1, 2, 0, 0, 0);
      checkOutput("lu_rn_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
      checkOutput("lu_rn_stall", 32'(STALL_COUNT), 32'd1);
      checkOutput("lu_rn_state", 32'(STATE), 32'd0);
      applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("lu_after_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();

      // XZR destination never hazards
      applyStimulus(1, 31, 0, 0, 1, 31, 0, 0, 0);
      checkOutput("xzr_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();
      checkOutput("xzr_stall", 32'(STALL_COUNT), 32'd1);

      // Rb match only counts when the instruction reads Rb
      applyStimulus(1, 0, 5, 0, 1, 5, 0, 0, 0);
      checkOutput("rb_unused_ctrl", 32'(ctrl), 32'(C_IDLE));
      applyStimulus(1, 0, 5, 1, 1, 5, 0, 0, 0);
      checkOutput("rb_used_ctrl", 32'(ctrl), 32'(C_STALL));
      tick();
      checkOutput("rb_used_stall", 32'(STALL_COUNT), 32'd2);

      // Invalid ID slot never stalls
      applyStimulus(0, 7, 0, 0, 1, 7, 0, 0, 0);
      checkOutput("id_invalid_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();

      // Memory wait: 3 not-ready cycles then release
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
         checkOutput($sformatf("memwait_ctrl%0d", i), 32'(ctrl), 32'(C_FREEZE));
         tick();
         checkOutput($sformatf("memwait_state%0d", i), 32'(STATE), 32'd1);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("memwait_release_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();
      checkOutput("memwait_release_state", 32'(STATE), 32'd0);
      checkOutput("memwait_stall", 32'(STALL_COUNT), 32'd5);

      // Taken branch beats load-use
      applyStimulus(1, 2, 0, 0, 1, 2, 1, 0, 0);
      checkOutput("flush_lu_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick();
      checkOutput("flush_lu_count", 32'(FLUSH_COUNT), 32'd1);
      checkOutput("flush_lu_stall", 32'(STALL_COUNT), 32'd5);

      // Taken branch beats a not-ready memory request
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0);
      checkOutput("flush_mem_ctrl", 32'(ctrl), 32'(C_FLUSH));
      tick();
      checkOutput("flush_mem_state", 32'(STATE), 32'd0);
      checkOutput("flush_mem_count", 32'(FLUSH_COUNT), 32'd2);

      // Zero-wait memory costs nothing
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1);
      checkOutput("zero_wait_ctrl", 32'(ctrl), 32'(C_IDLE));
      tick();
      checkOutput("zero_wait_state", 32'(STATE), 32'd0);
      checkOutput("zero_wait_stall", 32'(STALL_COUNT), 32'd5);

      // Watchdog: four wait cycles with no ready trips ERROR
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
         checkOutput($sformatf("wd_ctrl%0d", i), 32'(ctrl), 32'(C_FREEZE));
         tick();
         if (i < 3) begin
            checkOutput($sformatf("wd_state%0d", i), 32'(STATE), 32'd1);
         end
      end
      checkOutput("wd_state_err", 32'(STATE), 32'd2);
      checkOutput("wd_memerr", 32'(MEM_ERR), 32'd1);
      checkOutput("wd_stall", 32'(STALL_COUNT), 32'd9);

      // ERROR ignores a late ready and a taken branch, and stops counting
      applyStimulus(1, 2, 0, 0, 1, 2, 1, 1, 1);
      checkOutput("err_ctrl", 32'(ctrl), 32'(C_FREEZE));
      tick();
      checkOutput("err_state", 32'(STATE), 32'd2);
      checkOutput("err_memerr", 32'(MEM_ERR), 32'd1);
      checkOutput("err_stall", 32'(STALL_COUNT), 32'd9);
      checkOutput("err_flush", 32'(FLUSH_COUNT), 32'd2);

      // Asynchronous reset out of ERROR, no clock edge needed
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      RESET = 1'b1;
      #1;
      checkOutput("arst_state", 32'(STATE), 32'd0);
      checkOutput("arst_memerr", 32'(MEM_ERR), 32'd0);
      checkOutput("arst_stall", 32'(STALL_COUNT), 32'd0);
      checkOutput("arst_flush", 32'(FLUSH_COUNT), 32'd0);
      checkOutput("arst_ctrl", 32'(ctrl), 32'(C_RESET));
      tick();
      RESET = 1'b0;

      // Stall counter saturates at all-ones
      applyStimulus(1, 3, 0, 0, 1, 3, 0, 0, 0);
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) checkOutput("sat_stall14", 32'(STALL_COUNT), 32'd14);
      end
      checkOutput("sat_stall20", 32'(STALL_COUNT), 32'd15);

      // Flush counter saturates at all-ones
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      checkOutput("sat_flush20", 32'(FLUSH_COUNT), 32'd15);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
